// File: rtl/display_pkg.sv
// Shared encodings for the display scan scheduler: source states, glyph codes
// and the fixed message glyph table.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_CODE   = 2'd2,
    ST_MSG    = 2'd3
  } state_e;

  localparam logic [3:0] GLYPH_BLANK = 4'hF;
  localparam logic [3:0] GLYPH_ERR   = 4'hE;
  localparam logic [3:0] GLYPH_C     = 4'hC;

  // Row per message code; nibble n of a row is the glyph for digit n.
  localparam logic [3:0][15:0] MSG_TABLE = {
    16'h1DAB,
    16'hBAD0,
    16'hDCBA,
    16'hABCD
  };

  function automatic logic [3:0] bcd_glyph(input logic [3:0] nib);
    return (nib > 4'd9) ? GLYPH_ERR : nib;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Digit multiplex timer: prescaler, digit index and end-of-frame strobe.
// wrap_o/frame_end_o are combinational and valid in the last cycle of a digit.
module scan_timer #(
  parameter int PRESCALE = 1000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  output logic [1:0] digit_idx_o,
  output logic       wrap_o,
  output logic       frame_end_o
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;

  assign wrap_o      = (presc_q == PW'(PRESCALE - 1));
  assign frame_end_o = wrap_o && (idx_q == 2'd3);
  assign digit_idx_o = idx_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (wrap_o) begin
      presc_q <= '0;
      idx_q   <= idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_scheduler.sv
// Four-digit multiplexed display scheduler choosing between idle, credit, code
// and timed status messages; sources only switch on frame boundaries.
module display_scan_scheduler
  import display_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int MSG_HOLD = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] code_in,
  input  logic [7:0] credit_in,
  input  logic       msg_req,
  input  logic [1:0] msg_code,
  output logic [3:0] digit_select,
  output logic [3:0] out,
  output logic [1:0] src
);

  localparam int HW = $clog2(MSG_HOLD + 1);

  logic [1:0] digit_idx, idx_next;
  logic       wrap, frame_end;

  state_e        state_q, state_d, fallback;
  logic [HW-1:0] hold_q, hold_d;
  logic          pend_q, pend_d;
  logic [1:0]    pend_code_q, pend_code_d;
  logic [1:0]    msg_sel_q, msg_sel_d;
  logic [7:0]    code_snap_q, code_snap_d;
  logic [7:0]    credit_snap_q, credit_snap_d;
  logic [3:0]    dsel_q, dsel_d;
  logic [3:0]    glyph_q, glyph_d, glyph_sel;

  scan_timer #(.PRESCALE(PRESCALE)) u_scan_timer (
    .clk_i       (clk),
    .reset_i     (reset),
    .digit_idx_o (digit_idx),
    .wrap_o      (wrap),
    .frame_end_o (frame_end)
  );

  assign idx_next = digit_idx + 2'd1;

  always_comb begin
    fallback      = code_valid ? ST_CODE : ((credit_in != 8'd0) ? ST_CREDIT : ST_IDLE);
    state_d       = state_q;
    hold_d        = hold_q;
    msg_sel_d     = msg_sel_q;
    code_snap_d   = code_snap_q;
    credit_snap_d = credit_snap_q;
    pend_d        = pend_q | msg_req;
    pend_code_d   = msg_req ? msg_code : pend_code_q;
    if (frame_end) begin
      code_snap_d   = code_in;
      credit_snap_d = credit_in;
      pend_d        = 1'b0;
      // A request landing on the boundary cycle itself is honoured immediately.
      if (pend_q || msg_req) begin
        state_d   = ST_MSG;
        hold_d    = HW'(MSG_HOLD);
        msg_sel_d = msg_req ? msg_code : pend_code_q;
      end else if (state_q == ST_MSG && hold_q > HW'(1)) begin
        hold_d = hold_q - 1'b1;
      end else begin
        state_d = fallback;
        hold_d  = '0;
      end
    end
  end

  // Glyph for the digit about to be lit, using the source of the coming frame.
  always_comb begin
    glyph_sel = GLYPH_BLANK;
    case (state_d)
      ST_CREDIT: begin
        if (idx_next == 2'd0)      glyph_sel = bcd_glyph(credit_snap_d[3:0]);
        else if (idx_next == 2'd1) glyph_sel = bcd_glyph(credit_snap_d[7:4]);
      end
      ST_CODE: begin
        if (idx_next == 2'd0)      glyph_sel = bcd_glyph(code_snap_d[3:0]);
        else if (idx_next == 2'd1) glyph_sel = bcd_glyph(code_snap_d[7:4]);
        else if (idx_next == 2'd3) glyph_sel = GLYPH_C;
      end
      ST_MSG:  glyph_sel = MSG_TABLE[msg_sel_d][{idx_next, 2'b00} +: 4];
      default: glyph_sel = GLYPH_BLANK;
    endcase
    dsel_d  = wrap ? (4'b0001 << idx_next) : dsel_q;
    glyph_d = wrap ? glyph_sel : glyph_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      pend_q        <= 1'b0;
      pend_code_q   <= '0;
      msg_sel_q     <= '0;
      code_snap_q   <= '0;
      credit_snap_q <= '0;
      dsel_q        <= 4'b0001;
      glyph_q       <= GLYPH_BLANK;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      pend_q        <= pend_d;
      pend_code_q   <= pend_code_d;
      msg_sel_q     <= msg_sel_d;
      code_snap_q   <= code_snap_d;
      credit_snap_q <= credit_snap_d;
      dsel_q        <= dsel_d;
      glyph_q       <= glyph_d;
    end
  end

  assign digit_select = dsel_q;
  assign out          = glyph_q;
  assign src          = state_q;

endmodule
